sbp_lookup_arbiter: RTL and testbench

Front-end controller that shares the single per-cycle input slot of the scalable pipelined lookup pipeline between a streaming IP lookup port and a table-update command port. Updates are buffered in a small FIFO and inserted into idle or forced slots under a bounded lookup-burst policy, so neither stream starves. A valid-tag shift register tracks in-flight lookups, and the block presents pipeline results with a result-valid strobe. The block sits directly upstream of `sbp_lookup` and drives its `upd_*` and `ip_addr_i` inputs.

---
 rtl/sbp_lookup_arbiter.sv | 144 ++++++++++++++
 tb/tb_sbp_lookup_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbp_lookup_arbiter.sv
// Front-end arbiter for the sbp_lookup pipeline: shares the single per-cycle input slot
// between streaming lookups and FIFO-buffered table updates, and tags lookups to qualify results.
module sbp_lookup_arbiter #(
  parameter int STAGE_ID_BITS    = 6,
  parameter int LOCATION_BITS    = 11,
  parameter int RESULT_BITS      = 24,
  parameter int PIPE_LATENCY     = 33,
  parameter int UPD_FIFO_DEPTH   = 4,
  parameter int MAX_LOOKUP_BURST = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              lkp_valid_i,
  output logic                              lkp_ready_o,
  input  logic [31:0]                       lkp_ip_addr_i,
  input  logic                              upd_valid_i,
  output logic                              upd_ready_o,
  input  logic [31:0]                       upd_prefix_i,
  input  logic [5:0]                        upd_length_i,
  input  logic [STAGE_ID_BITS-1:0]          upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0]          upd_location_i,
  input  logic [STAGE_ID_BITS-1:0]          upd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0]          upd_childs_location_i,
  input  logic [1:0]                        upd_childs_lr_i,
  output logic                              pl_upd_o,
  output logic [31:0]                       pl_ip_addr_o,
  output logic [5:0]                        pl_length_o,
  output logic [STAGE_ID_BITS-1:0]          pl_stage_id_o,
  output logic [LOCATION_BITS-1:0]          pl_location_o,
  output logic [STAGE_ID_BITS-1:0]          pl_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0]          pl_childs_location_o,
  output logic [1:0]                        pl_childs_lr_o,
  input  logic [RESULT_BITS-1:0]            pl_result_i,
  input  logic [31:0]                       pl_ip_addr_i,
  output logic                              res_valid_o,
  output logic [RESULT_BITS-1:0]            res_o,
  output logic [31:0]                       res_ip_addr_o,
  output logic                              upd_issued_o,
  output logic [$clog2(UPD_FIFO_DEPTH):0]   upd_fifo_count_o
);
  localparam int PTR_W  = $clog2(UPD_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BCNT_W = $clog2(MAX_LOOKUP_BURST + 1);
  localparam int PAY_W  = 32 + 6 + 2*STAGE_ID_BITS + 2*LOCATION_BITS + 2;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(UPD_FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] BMAX    = BCNT_W'(MAX_LOOKUP_BURST);

  logic [PAY_W-1:0]        mem_q [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [PAY_W-1:0]        slot_q, slot_d;
  logic                    pl_upd_q, pl_upd_d, issued_q, issued_d;
  logic [PIPE_LATENCY:0]   vld_pipe_q, vld_pipe_d;
  logic                    res_valid_q, res_valid_d;
  logic [RESULT_BITS-1:0]  res_q, res_d;
  logic [31:0]             res_ip_q, res_ip_d;

  logic             empty, full, force_upd, ug, lg, push, pop;
  logic [PAY_W-1:0] upd_pay, head;

  assign upd_pay = {upd_prefix_i, upd_length_i, upd_stage_id_i, upd_location_i,
                    upd_childs_stage_id_i, upd_childs_location_i, upd_childs_lr_i};
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    force_upd   = !empty && (bcnt_q == BMAX);
    lkp_ready_o = !rst && !force_upd;
    upd_ready_o = rst || !full;
    ug          = !rst && !empty && (force_upd || !lkp_valid_i);
    lg          = lkp_valid_i && lkp_ready_o;
    push        = !rst && upd_valid_i && !full;
    pop         = ug;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    bcnt_d = bcnt_q;
    if (ug || empty)        bcnt_d = '0;
    else if (lg && bcnt_q != BMAX) bcnt_d = bcnt_q + 1'b1;

    slot_d   = '0;
    pl_upd_d = 1'b0;
    issued_d = 1'b0;
    if (ug) begin
      slot_d   = head;
      pl_upd_d = 1'b1;
      issued_d = 1'b1;
    end else if (lg) begin
      slot_d = {lkp_ip_addr_i, (PAY_W-32)'(0)};
    end

    // bit 0 marks the slot register holding a lookup; the top bit lines up with pl_result_i
    vld_pipe_d  = {vld_pipe_q[PIPE_LATENCY-1:0], lg};
    res_valid_d = vld_pipe_q[PIPE_LATENCY];
    res_d       = vld_pipe_q[PIPE_LATENCY] ? pl_result_i  : res_q;
    res_ip_d    = vld_pipe_q[PIPE_LATENCY] ? pl_ip_addr_i : res_ip_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= upd_pay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bcnt_q      <= '0;
      slot_q      <= '0;
      pl_upd_q    <= 1'b0;
      issued_q    <= 1'b0;
      vld_pipe_q  <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_ip_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bcnt_q      <= bcnt_d;
      slot_q      <= slot_d;
      pl_upd_q    <= pl_upd_d;
      issued_q    <= issued_d;
      vld_pipe_q  <= vld_pipe_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_ip_q    <= res_ip_d;
    end
  end

  assign {pl_ip_addr_o, pl_length_o, pl_stage_id_o, pl_location_o,
          pl_childs_stage_id_o, pl_childs_location_o, pl_childs_lr_o} = slot_q;
  assign pl_upd_o         = pl_upd_q;
  assign upd_issued_o     = issued_q;
  assign res_valid_o      = res_valid_q;
  assign res_o            = res_q;
  assign res_ip_addr_o    = res_ip_q;
  assign upd_fifo_count_o = count_q;

endmodule

// File: tb/tb_sbp_lookup_arbiter.sv
// Directed bench for sbp_lookup_arbiter; the pipeline is modelled as a pure delay line
// and queue-based monitors check result order/latency and update slot contents.
module tb_sbp_lookup_arbiter;
  localparam int PL = 33, BURST = 16, DEPTH = 4, SB = 6, LB = 11, RB = 24;

  logic          clk, rst;
  logic          lkp_valid_i, lkp_ready_o, upd_valid_i, upd_ready_o;
  logic [31:0]   lkp_ip_addr_i, upd_prefix_i;
  logic [5:0]    upd_length_i;
  logic [SB-1:0] upd_stage_id_i, upd_childs_stage_id_i;
  logic [LB-1:0] upd_location_i, upd_childs_location_i;
  logic [1:0]    upd_childs_lr_i;
  logic          pl_upd_o;
  logic [31:0]   pl_ip_addr_o;
  logic [5:0]    pl_length_o;
  logic [SB-1:0] pl_stage_id_o, pl_childs_stage_id_o;
  logic [LB-1:0] pl_location_o, pl_childs_location_o;
  logic [1:0]    pl_childs_lr_o;
  logic [RB-1:0] pl_result_i, res_o;
  logic [31:0]   pl_ip_addr_i, res_ip_addr_o;
  logic          res_valid_o, upd_issued_o;
  logic [2:0]    upd_fifo_count_o;

  sbp_lookup_arbiter #(.STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .RESULT_BITS(RB),
    .PIPE_LATENCY(PL), .UPD_FIFO_DEPTH(DEPTH), .MAX_LOOKUP_BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip_addr_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_prefix_i(upd_prefix_i), .upd_length_i(upd_length_i), .upd_stage_id_i(upd_stage_id_i),
    .upd_location_i(upd_location_i), .upd_childs_stage_id_i(upd_childs_stage_id_i),
    .upd_childs_location_i(upd_childs_location_i), .upd_childs_lr_i(upd_childs_lr_i),
    .pl_upd_o(pl_upd_o), .pl_ip_addr_o(pl_ip_addr_o), .pl_length_o(pl_length_o),
    .pl_stage_id_o(pl_stage_id_o), .pl_location_o(pl_location_o),
    .pl_childs_stage_id_o(pl_childs_stage_id_o), .pl_childs_location_o(pl_childs_location_o),
    .pl_childs_lr_o(pl_childs_lr_o), .pl_result_i(pl_result_i), .pl_ip_addr_i(pl_ip_addr_i),
    .res_valid_o(res_valid_o), .res_o(res_o), .res_ip_addr_o(res_ip_addr_o),
    .upd_issued_o(upd_issued_o), .upd_fifo_count_o(upd_fifo_count_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RB-1:0] exp_res(input logic [31:0] ip);
    return ip[23:0] ^ {ip[31:24], 16'hA5C3};
  endfunction

  // pipeline model: pure PL-cycle delay of the slot address, result derived from it
  logic [31:0] dl [PL];
  always @(posedge clk) begin
    dl[0] <= pl_ip_addr_o;
    for (int i = 1; i < PL; i++) dl[i] <= dl[i-1];
  end
  assign pl_ip_addr_i = dl[PL-1];
  assign pl_result_i  = exp_res(pl_ip_addr_i);

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [31:0] ip; int c; } lkp_t;
  lkp_t        lq[$];
  logic [73:0] uq[$];
  lkp_t        e;
  int cyc = 0, run = 0, res_cnt = 0, lkp_cnt = 0, upd_iss_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid_o) begin
      res_cnt++;
      if (lq.size() == 0) chk("res_unexp", res_valid_o, 0);
      else begin
        e = lq.pop_front();
        chk("res_ip", res_ip_addr_o, e.ip);
        chk("res_val", res_o, exp_res(e.ip));
        chk("res_lat", cyc, e.c + PL + 2);
      end
    end
    if (pl_upd_o || upd_issued_o) begin
      upd_iss_cnt++;
      chk("upd_iss", upd_issued_o, pl_upd_o);
      if (uq.size() == 0) chk("upd_unexp", pl_upd_o, 0);
      else chk("upd_slot", {pl_ip_addr_o, pl_length_o, pl_stage_id_o, pl_location_o,
                            pl_childs_stage_id_o, pl_childs_location_o, pl_childs_lr_o},
               uq.pop_front());
    end
    if (rst) begin
      lq.delete(); uq.delete(); run = 0;
    end else begin
      if (upd_fifo_count_o != 0 && run == BURST) chk("force", lkp_ready_o, 0);
      if (lkp_valid_i && lkp_ready_o) begin
        lq.push_back('{lkp_ip_addr_i, cyc});
        lkp_cnt++;
        run = (upd_fifo_count_o != 0) ? run + 1 : 0;
      end else run = 0;
      if (upd_valid_i && upd_ready_o)
        uq.push_back({upd_prefix_i, upd_length_i, upd_stage_id_i, upd_location_i,
                      upd_childs_stage_id_i, upd_childs_location_i, upd_childs_lr_i});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_upd(input int n);
    upd_prefix_i = 32'hAB000000 + 32'(n); upd_length_i = 6'(n + 1);
    upd_stage_id_i = SB'(n); upd_location_i = LB'(12'h100 + n);
    upd_childs_stage_id_i = SB'(7 - n); upd_childs_location_i = LB'(12'h200 + n);
    upd_childs_lr_i = 2'(n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int r0, u0, g, l0;
  bit stalled;

  initial begin
    rst = 1; lkp_valid_i = 0; lkp_ip_addr_i = 0; upd_valid_i = 0; set_upd(0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_lrdy", lkp_ready_o, 0);
    chk("rst_urdy", upd_ready_o, 1);
    chk("rst_plupd", pl_upd_o, 0);
    chk("rst_res", res_valid_o, 0);
    chk("rst_cnt", upd_fifo_count_o, 0);
    chk("rst_ip", pl_ip_addr_o, 0);
    tick(); rst = 0;

    // single lookup
    lkp_valid_i = 1; lkp_ip_addr_i = 32'h0A000001;
    @(negedge clk); chk("t1_rdy", lkp_ready_o, 1);
    tick(); lkp_valid_i = 0;
    @(negedge clk);
    chk("t1_plupd", pl_upd_o, 0);
    chk("t1_plip", pl_ip_addr_o, 32'h0A000001);
    chk("t1_pllen", pl_length_o, 0);
    r0 = res_cnt;
    repeat (40) tick();
    chk("t1_nres", res_cnt - r0, 1);
    chk("t1_hold", res_ip_addr_o, 32'h0A000001);

    // single update, idle lookups
    upd_valid_i = 1; upd_prefix_i = 32'hC0A80000; upd_length_i = 24; upd_stage_id_i = 3;
    upd_location_i = 11'h12; upd_childs_stage_id_i = 5; upd_childs_location_i = 11'h7FF;
    upd_childs_lr_i = 2;
    @(negedge clk); chk("t2_urdy", upd_ready_o, 1);
    tick(); upd_valid_i = 0;
    @(negedge clk); chk("t2_cnt1", upd_fifo_count_o, 1); chk("t2_early", pl_upd_o, 0);
    tick();
    @(negedge clk);
    chk("t2_plupd", pl_upd_o, 1); chk("t2_iss", upd_issued_o, 1);
    chk("t2_stage", pl_stage_id_o, 3); chk("t2_loc", pl_location_o, 11'h12);
    chk("t2_len", pl_length_o, 24); chk("t2_pfx", pl_ip_addr_o, 32'hC0A80000);
    chk("t2_cst", pl_childs_stage_id_o, 5); chk("t2_cloc", pl_childs_location_o, 11'h7FF);
    chk("t2_clr", pl_childs_lr_o, 2); chk("t2_cnt0", upd_fifo_count_o, 0);
    tick();
    @(negedge clk); chk("t2_pulse", upd_issued_o, 0);
    repeat (40) tick();

    // burst limit with one waiting update
    lkp_valid_i = 1; lkp_ip_addr_i = 32'h10000000;
    repeat (3) begin tick(); lkp_ip_addr_i++; end
    upd_valid_i = 1; set_upd(9);
    g = 0; stalled = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); upd_valid_i = 0; lkp_ip_addr_i++;
      @(negedge clk);
      if (!lkp_ready_o) begin stalled = 1; break; end
      g++;
    end
    chk("t3_grants", g, BURST);
    chk("t3_stall", stalled, 1);
    tick(); lkp_ip_addr_i++;
    @(negedge clk); chk("t3_slot", pl_upd_o, 1); chk("t3_resume", lkp_ready_o, 1);
    tick(); lkp_valid_i = 0;
    repeat (45) tick();

    // FIFO full with lookups held valid
    u0 = upd_iss_cnt; lkp_valid_i = 1; lkp_ip_addr_i = 32'h20000000;
    for (int n = 0; n < 4; n++) begin
      set_upd(n); upd_valid_i = 1;
      @(negedge clk); chk("t4_rdy", upd_ready_o, 1);
      tick(); lkp_ip_addr_i++;
    end
    set_upd(4);
    @(negedge clk); chk("t4_full", upd_ready_o, 0); chk("t4_cnt", upd_fifo_count_o, 4);
    for (int i = 0; i < 40 && !upd_ready_o; i++) begin
      tick(); lkp_ip_addr_i++;
      @(negedge clk);
    end
    chk("t4_late", upd_ready_o, 1);
    tick(); upd_valid_i = 0;
    repeat (110) begin tick(); lkp_ip_addr_i++; end
    lkp_valid_i = 0;
    repeat (50) tick();
    chk("t4_drain", upd_fifo_count_o, 0);
    chk("t4_niss", upd_iss_cnt - u0, 5);

    // reset with lookups in flight and updates queued
    lkp_valid_i = 1; lkp_ip_addr_i = 32'h30000000;
    for (int i = 0; i < 10; i++) begin
      upd_valid_i = (i == 1 || i == 2); set_upd(20 + i);
      tick(); lkp_ip_addr_i++;
    end
    upd_valid_i = 0; lkp_valid_i = 0; rst = 1;
    @(negedge clk); chk("t5_lrdy", lkp_ready_o, 0); chk("t5_urdy", upd_ready_o, 1);
    tick(); rst = 0;
    r0 = res_cnt; u0 = upd_iss_cnt;
    @(negedge clk); chk("t5_cnt", upd_fifo_count_o, 0);
    repeat (50) tick();
    chk("t5_nres", res_cnt - r0, 0);
    chk("t5_nupd", upd_iss_cnt - u0, 0);

    // random mix
    r0 = res_cnt; l0 = lkp_cnt;
    for (int i = 0; i < 2000; i++) begin
      lkp_valid_i = ($urandom_range(0, 9) < 7); lkp_ip_addr_i = $urandom;
      upd_valid_i = ($urandom_range(0, 9) < 2);
      upd_prefix_i = $urandom; upd_length_i = 6'($urandom); upd_stage_id_i = SB'($urandom);
      upd_location_i = LB'($urandom); upd_childs_stage_id_i = SB'($urandom);
      upd_childs_location_i = LB'($urandom); upd_childs_lr_i = 2'($urandom);
      tick();
    end
    lkp_valid_i = 0; upd_valid_i = 0;
    repeat (60) tick();
    chk("t6_res", res_cnt - r0, lkp_cnt - l0);
    chk("t6_lq", lq.size(), 0);
    chk("t6_uq", uq.size(), 0);
    chk("t6_cnt", upd_fifo_count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
